// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// ID-stage resolver for the fetch-side gshare predictor. Carries each fetched PC and its
// predicted next-PC into ID, compares the prediction with the next-PC computed in ID,
// raises mispredict/redirect to the PC mux, drives the predictor update port and keeps
// saturating branch and misprediction counters.
module branch_resolve_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             is_stall,
   input  logic [31:0]      IF_pc,
   input  logic [31:0]      IF_pred_pc,
   input  logic             ID_branch,
   input  logic             ID_jump,
   input  logic             ID_bcond,
   input  logic [31:0]      ID_target,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic             upd_valid,
   output logic [31:0]      upd_pc,
   output logic             upd_taken,
   output logic [31:0]      upd_target,
   output logic             id_valid,
   output logic             in_recovery,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mp_cnt
);

   localparam logic [0:0]       ST_IDLE    = 1'b0;
   localparam logic [0:0]       ST_RECOVER = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [31:0]      id_pc_r;
   logic [31:0]      id_pred_r;
   logic             id_valid_r;
   logic [0:0]       state_r;
   logic [CNT_W-1:0] br_cnt_r;
   logic [CNT_W-1:0] mp_cnt_r;

   logic             taken_s;
   logic [31:0]      actual_s;
   logic             resolve_s;
   logic             mispredict_s;
   logic             upd_valid_s;

   // Resolve the instruction held in ID: real next-PC versus carried prediction.
   // Reset gates resolution so no update or redirect leaks out during a reset cycle.
   always_comb begin
      taken_s      = (ID_branch & ID_bcond) | ID_jump;
      actual_s     = taken_s ? ID_target : (id_pc_r + 32'd4);
      resolve_s    = id_valid_r & ~is_stall & ~reset;
      mispredict_s = resolve_s & (actual_s != id_pred_r);
      upd_valid_s  = resolve_s & (ID_branch | ID_jump);
   end

   // Drive redirect and predictor-update outputs, zeroed whenever they are not valid.
   always_comb begin
      mispredict = mispredict_s;
      if (mispredict_s) begin
         redirect_pc = actual_s;
      end else begin
         redirect_pc = 32'd0;
      end
      upd_valid = upd_valid_s;
      if (upd_valid_s) begin
         upd_pc     = id_pc_r;
         upd_taken  = taken_s;
         upd_target = ID_target;
      end else begin
         upd_pc     = 32'd0;
         upd_taken  = 1'b0;
         upd_target = 32'd0;
      end
   end

   // IF->ID carry registers; a mispredict squashes the instruction entering ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         id_pc_r    <= 32'd0;
         id_pred_r  <= 32'd0;
         id_valid_r <= 1'b0;
      end else if (!is_stall) begin
         id_pc_r    <= IF_pc;
         id_pred_r  <= IF_pred_pc;
         id_valid_r <= ~mispredict_s;
      end else begin
         id_pc_r    <= id_pc_r;
         id_pred_r  <= id_pred_r;
         id_valid_r <= id_valid_r;
      end
   end

   // Recovery FSM: one bubble after a mispredict, extended while the pipe is stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (mispredict_s) begin
                  state_r <= ST_RECOVER;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RECOVER: begin
               if (!is_stall) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RECOVER;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Saturating performance counters for resolved branches and mispredictions.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_cnt_r <= {CNT_W{1'b0}};
         mp_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (upd_valid_s && (br_cnt_r != CNT_MAX)) begin
            br_cnt_r <= br_cnt_r + CNT_ONE;
         end else begin
            br_cnt_r <= br_cnt_r;
         end
         if (mispredict_s && (mp_cnt_r != CNT_MAX)) begin
            mp_cnt_r <= mp_cnt_r + CNT_ONE;
         end else begin
            mp_cnt_r <= mp_cnt_r;
         end
      end
   end

   assign id_valid    = id_valid_r;
   assign in_recovery = (state_r == ST_RECOVER);
   assign br_cnt      = br_cnt_r;
   assign mp_cnt      = mp_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model of the resolver.
module tb_branch_resolve_unit;

   logic        clk;
   logic        reset;
   logic        is_stall;
   logic [31:0] IF_pc;
   logic [31:0] IF_pred_pc;
   logic        ID_branch;
   logic        ID_jump;
   logic        ID_bcond;
   logic [31:0] ID_target;

   logic        mispredict, upd_valid, upd_taken, id_valid, in_recovery;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] br_cnt, mp_cnt;

   logic        mispredict4, upd_valid4, upd_taken4, id_valid4, in_recovery4;
   logic [31:0] redirect_pc4, upd_pc4, upd_target4;
   logic [3:0]  br_cnt4, mp_cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   logic [31:0] m_pc, m_pred;
   logic        m_valid, m_rec;
   longint      m_br, m_mp, m_br4, m_mp4;

   branch_resolve_unit dut (
      .clk(clk), .reset(reset), .is_stall(is_stall), .IF_pc(IF_pc), .IF_pred_pc(IF_pred_pc),
      .ID_branch(ID_branch), .ID_jump(ID_jump), .ID_bcond(ID_bcond), .ID_target(ID_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .id_valid(id_valid), .in_recovery(in_recovery), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
   );

   branch_resolve_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .is_stall(is_stall), .IF_pc(IF_pc), .IF_pred_pc(IF_pred_pc),
      .ID_branch(ID_branch), .ID_jump(ID_jump), .ID_bcond(ID_bcond), .ID_target(ID_target),
      .mispredict(mispredict4), .redirect_pc(redirect_pc4), .upd_valid(upd_valid4),
      .upd_pc(upd_pc4), .upd_taken(upd_taken4), .upd_target(upd_target4),
      .id_valid(id_valid4), .in_recovery(in_recovery4), .br_cnt(br_cnt4), .mp_cnt(mp_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic longint sat_add(input longint v, input bit inc, input longint cap);
      longint r;
      r = v + (inc ? 64'sd1 : 64'sd0);
      return (r > cap) ? cap : r;
   endfunction

   // One clock cycle: drive inputs, check comb outputs, clock, advance model, check state.
   task automatic step(input logic rst, input logic st, input logic [31:0] ipc,
                       input logic [31:0] ipred, input logic br, input logic jp,
                       input logic bc, input logic [31:0] tgt);
      logic        tk, res, e_mp, e_uv;
      logic [31:0] act;
      reset = rst; is_stall = st; IF_pc = ipc; IF_pred_pc = ipred;
      ID_branch = br; ID_jump = jp; ID_bcond = bc; ID_target = tgt;
      tk   = (br && bc) || jp;
      act  = tk ? tgt : (m_pc + 32'd4);
      res  = !rst && m_valid && !st;
      e_mp = res && (act != m_pred);
      e_uv = res && (br || jp);
      #1;
      check("mispredict",  {63'd0, mispredict}, {63'd0, e_mp});
      check("redirect_pc", {32'd0, redirect_pc}, {32'd0, (e_mp ? act : 32'd0)});
      check("upd_valid",   {63'd0, upd_valid}, {63'd0, e_uv});
      check("upd_pc",      {32'd0, upd_pc}, {32'd0, (e_uv ? m_pc : 32'd0)});
      check("upd_taken",   {63'd0, upd_taken}, {63'd0, (e_uv && tk)});
      check("upd_target",  {32'd0, upd_target}, {32'd0, (e_uv ? tgt : 32'd0)});
      check("mispredict4", {63'd0, mispredict4}, {63'd0, e_mp});
      @(posedge clk);
      #1;
      if (rst) begin
         m_pc = 32'd0; m_pred = 32'd0; m_valid = 1'b0; m_rec = 1'b0;
         m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
      end else begin
         if (!st) begin
            m_pc = ipc; m_pred = ipred; m_valid = !e_mp;
         end
         if (e_mp) m_rec = 1'b1;
         else if (!st) m_rec = 1'b0;
         m_br  = sat_add(m_br,  e_uv, 64'sd4294967295);
         m_mp  = sat_add(m_mp,  e_mp, 64'sd4294967295);
         m_br4 = sat_add(m_br4, e_uv, 64'sd15);
         m_mp4 = sat_add(m_mp4, e_mp, 64'sd15);
      end
      check("id_valid",    {63'd0, id_valid}, {63'd0, m_valid});
      check("in_recovery", {63'd0, in_recovery}, {63'd0, m_rec});
      check("br_cnt",      {32'd0, br_cnt}, m_br);
      check("mp_cnt",      {32'd0, mp_cnt}, m_mp);
      check("br_cnt4",     {60'd0, br_cnt4}, m_br4);
      check("mp_cnt4",     {60'd0, mp_cnt4}, m_mp4);
   endtask

   initial begin
      logic [31:0] ipc, ipred, tgt;
      logic        st, br, jp, bc, rst;
      int          kind;
      reset = 1'b1; is_stall = 1'b0; IF_pc = 32'd0; IF_pred_pc = 32'd0;
      ID_branch = 1'b0; ID_jump = 1'b0; ID_bcond = 1'b0; ID_target = 32'd0;
      m_pc = 32'd0; m_pred = 32'd0; m_valid = 1'b0; m_rec = 1'b0;
      m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
      @(posedge clk); #1;

      // reset state
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44);
      check("rst_id_valid", {63'd0, id_valid}, 64'd0);
      check("rst_br_cnt", {32'd0, br_cnt}, 64'd0);

      // correctly predicted taken branch at 0x100 -> 0x140
      step(1'b0, 1'b0, 32'h100, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h140, 32'h144, 1'b1, 1'b0, 1'b1, 32'h140);
      check("ct_br_cnt", {32'd0, br_cnt}, 64'd1);
      check("ct_mp_cnt", {32'd0, mp_cnt}, 64'd0);

      // load 0x200 (pred 0x204), then a taken branch to 0x180 held by 3 stall cycles
      step(1'b0, 1'b0, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 32'h204, 32'h208, 1'b1, 1'b0, 1'b1, 32'h180);
      check("stall_mp_cnt", {32'd0, mp_cnt}, 64'd0);
      step(1'b0, 1'b0, 32'h204, 32'h208, 1'b1, 1'b0, 1'b1, 32'h180);
      check("wnt_in_recovery", {63'd0, in_recovery}, 64'd1);
      check("wnt_id_valid", {63'd0, id_valid}, 64'd0);
      check("wnt_mp_cnt", {32'd0, mp_cnt}, 64'd1);

      // recovery bubble: no update; load non-branch 0x300 predicted 0x400
      step(1'b0, 1'b0, 32'h300, 32'h400, 1'b1, 1'b0, 1'b1, 32'h500);
      check("rec_br_cnt", {32'd0, br_cnt}, 64'd2);
      check("rec_exit", {63'd0, in_recovery}, 64'd0);

      // BTB alias: non-branch at 0x300 -> redirect 0x304
      step(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("alias_br_cnt", {32'd0, br_cnt}, 64'd2);
      check("alias_mp_cnt", {32'd0, mp_cnt}, 64'd2);

      // PC wrap: 0xFFFFFFFC not taken predicted 0
      step(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, 32'h80);
      check("wrap_mp_cnt", {32'd0, mp_cnt}, 64'd2);

      // reset while in recovery
      step(1'b0, 1'b0, 32'h20, 32'h24, 1'b0, 1'b1, 1'b0, 32'h50);
      check("pre_rst_rec", {63'd0, in_recovery}, 64'd1);
      step(1'b1, 1'b0, 32'h30, 32'h34, 1'b1, 1'b0, 1'b1, 32'h90);
      check("rr_id_valid", {63'd0, id_valid}, 64'd0);
      check("rr_in_recovery", {63'd0, in_recovery}, 64'd0);
      check("rr_mp_cnt", {32'd0, mp_cnt}, 64'd0);

      // saturation: 20 correctly predicted not-taken branches
      for (int i = 0; i <= 20; i++)
         step(1'b0, 1'b0, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i),
              1'b1, 1'b0, 1'b0, 32'h2000);
      check("sat_br_cnt4", {60'd0, br_cnt4}, 64'd15);
      check("sat_br_cnt", {32'd0, br_cnt}, 64'd20);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 199) == 0);
         st    = ($urandom_range(0, 4) == 0);
         ipc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         ipred = $urandom_range(0, 1) ? (ipc + 32'd4) : ($urandom() & 32'hFFFF_FFFC);
         kind  = $urandom_range(0, 3);
         br    = (kind == 1) || (kind == 2);
         jp    = (kind == 3);
         bc    = $urandom_range(0, 1);
         tgt   = $urandom_range(0, 1) ? m_pred : ($urandom() & 32'hFFFF_FFFC);
         step(rst, st, ipc, ipred, br, jp, bc, tgt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
